// File: rtl/vec_overlap_scan.sv
// vec_overlap_scan: chunked AND-OR overlap detector returning hit and lowest match index.
// Define OVERLAP_COUNT_EN to add the match_cnt popcount output and its accumulator.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// SCAN  | evaluating one CHUNK-bit slice of a & b per cycle
// DONE  | result held on outputs until out_ready
module vec_overlap_scan #(
    parameter  int WIDTH  = 65,
    parameter  int CHUNK  = 16,
    localparam int NBEATS = (WIDTH + CHUNK - 1) / CHUNK,
    localparam int IDXW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
`ifdef OVERLAP_COUNT_EN
    ,
    localparam int CNTW   = $clog2(WIDTH + 1)
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             hit,
    output logic [IDXW-1:0]  first_idx
`ifdef OVERLAP_COUNT_EN
    ,
    output logic [CNTW-1:0]  match_cnt
`endif
);

    localparam int BEATW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int PADW  = NBEATS * CHUNK;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q;
    logic [BEATW-1:0] beat;
    logic [PADW-1:0]  and_pad;
    logic [CHUNK-1:0] slice;
    logic [IDXW-1:0]  slice_idx;
    logic             accept;
    logic             last_beat;

    assign in_ready  = (state == IDLE) & ~rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign last_beat = (beat == BEATW'(NBEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = SCAN;
            SCAN:    if (last_beat) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Padding above WIDTH is zero so the last partial beat cannot produce a false match.
    always_comb begin
        and_pad            = '0;
        and_pad[WIDTH-1:0] = a_q & b_q;
        slice              = CHUNK'(and_pad >> (int'(beat) * CHUNK));
    end

    always_comb begin
        slice_idx = '0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (slice[i]) slice_idx = IDXW'(int'(beat) * CHUNK + i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            beat      <= '0;
            hit       <= 1'b0;
            first_idx <= '0;
        end else if (accept) begin
            a_q       <= a;
            b_q       <= b;
            beat      <= '0;
            hit       <= 1'b0;
            first_idx <= '0;
        end else if (state == SCAN) begin
            if (!last_beat) beat <= beat + 1'b1;
            if ((slice != '0) && !hit) begin
                hit       <= 1'b1;
                first_idx <= slice_idx;
            end
        end
    end

`ifdef OVERLAP_COUNT_EN
    logic [CNTW-1:0] slice_cnt;

    always_comb begin
        slice_cnt = '0;
        for (int i = 0; i < CHUNK; i++) begin
            slice_cnt = slice_cnt + CNTW'(slice[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || accept)       match_cnt <= '0;
        else if (state == SCAN)  match_cnt <= match_cnt + slice_cnt;
    end
`endif

endmodule
